// File: rtl/iob_eth_pkg.sv
// Shared constants for the Ethernet receive path.
// Holds the SFD and preamble codes, the CRC-32 polynomial and good-frame residue,
// the receiver FSM encoding and a byte-wide CRC-32 step function.
// The CRC register is kept in polynomial (MSB-first) order. Each byte is shifted
// in LSB first, which is the order its bits appear on the wire.
package iob_eth_pkg;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP,
    ST_COMMIT
  } rx_state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC_POLY : 32'h0);
    return c;
  endfunction
endpackage

// File: rtl/iob_eth_crc32.sv
// Byte-wide Ethernet CRC-32 accumulator. The register starts at 0xFFFFFFFF.
// Ports:
//   clk_i, arst_i  clock, async active-high reset
//   cke_i          clock enable; the state is frozen when low
//   clr_i          reload the initial value (this takes priority over en_i)
//   en_i, data_i   fold one byte into the CRC
//   crc_o          raw CRC register. It equals CRC_RESIDUE after a good frame plus its FCS.
module iob_eth_crc32
  import iob_eth_pkg::*;
(
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        cke_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] r_crc;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)          r_crc <= '1;
    else if (cke_i) begin
      if (clr_i)         r_crc <= '1;
      else if (en_i)     r_crc <= crc32_byte(r_crc, data_i);
    end
  end

  assign crc_o = r_crc;
endmodule

// File: rtl/iob_eth_rx_multislot.sv
// Ethernet MAC receiver that writes frames into a ring of NSLOTS frame slots.
// It takes MII (4b, low nibble first) or GMII (8b) data and strips the preamble and SFD.
// It checks the CRC-32 and queues {slot,len,status} descriptors for the DMA.
// Ports:
//   clk_i, arst_i, cke_i          PHY RX clock, async active-high reset, clock enable
//   rx_dv_i, rx_er_i, rx_data_i   PHY receive interface
//   wr_en_o, wr_addr_o, wr_data_o byte writes to the buffer RAM, addressed as {slot, offset}
//   desc_*_o, desc_ack_i          head of the completed-frame queue, and its pop strobe
//   drop_cnt_o                    saturating count of discarded frames
module iob_eth_rx_multislot
  import iob_eth_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int NSLOTS_LOG2 = 2,
  parameter int SLOT_ADDR_W = 11,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518
) (
  input  logic                             clk_i,
  input  logic                             arst_i,
  input  logic                             cke_i,
  input  logic                             rx_dv_i,
  input  logic                             rx_er_i,
  input  logic [DATA_W-1:0]                rx_data_i,
  output logic                             wr_en_o,
  output logic [NSLOTS_LOG2+SLOT_ADDR_W-1:0] wr_addr_o,
  output logic [7:0]                       wr_data_o,
  output logic                             desc_valid_o,
  output logic [NSLOTS_LOG2-1:0]           desc_slot_o,
  output logic [SLOT_ADDR_W-1:0]           desc_len_o,
  output logic [1:0]                       desc_err_o,
  input  logic                             desc_ack_i,
  output logic [15:0]                      drop_cnt_o
);
  localparam int NSLOTS = 1 << NSLOTS_LOG2;
  localparam int CNT_W  = NSLOTS_LOG2 + 1;
  localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(NSLOTS);
  localparam logic [SLOT_ADDR_W-1:0] MIN_L    = SLOT_ADDR_W'(MIN_LEN);
  localparam logic [SLOT_ADDR_W-1:0] MAX_L    = SLOT_ADDR_W'(MAX_LEN);

  rx_state_t r_state, w_state_nxt;

  logic       w_byte_done, w_sfd;
  logic [7:0] w_byte;
  logic       w_wr, w_push, w_drop, w_start, w_pop, w_full, w_crc_err;
  logic [31:0] w_crc;

  logic [SLOT_ADDR_W-1:0] r_byte_cnt;
  logic [NSLOTS_LOG2-1:0] r_wr_slot, r_head;
  logic [CNT_W-1:0]       r_count;
  logic                   r_er, r_wr_en;
  logic [NSLOTS_LOG2+SLOT_ADDR_W-1:0] r_wr_addr;
  logic [7:0]             r_wr_data;
  logic [15:0]            r_drop_cnt;
  logic [NSLOTS-1:0][SLOT_ADDR_W-1:0] r_q_len;
  logic [NSLOTS-1:0][1:0]             r_q_err;

  // Nibble/byte front end. It produces the assembled byte, a byte-complete strobe
  // (meaningful in DATA) and SFD detection (meaningful in PRE).
  if (DATA_W == 4) begin : g_mii
    logic [3:0] r_lo;
    logic       r_phase;
    // Outside DATA, every nibble lands in r_lo so that PRE can see the 5-then-D
    // SFD pair. The phase is cleared there too, which discards any trailing odd nibble.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        r_lo    <= '0;
        r_phase <= 1'b0;
      end else if (cke_i && rx_dv_i) begin
        if (r_state == ST_DATA) begin
          r_phase <= ~r_phase;
          if (!r_phase) r_lo <= rx_data_i;
        end else begin
          r_lo    <= rx_data_i;
          r_phase <= 1'b0;
        end
      end
    end
    assign w_byte      = {rx_data_i, r_lo};
    assign w_byte_done = r_phase;
    assign w_sfd       = (rx_data_i == SFD_NIB) && (r_lo == PRE_NIB);
  end else begin : g_gmii
    assign w_byte      = rx_data_i;
    assign w_byte_done = 1'b1;
    assign w_sfd       = (rx_data_i == SFD);
  end

  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = desc_ack_i && (r_count != '0);
  assign w_crc_err = (w_crc != CRC_RESIDUE);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     r_state <= ST_IDLE;
    else if (cke_i) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: if (rx_dv_i) w_state_nxt = ST_PRE;
      ST_PRE: begin
        if (!rx_dv_i) w_state_nxt = ST_IDLE;
        else if (w_sfd) begin
          if (w_full) begin
            w_state_nxt = ST_DROP;
            w_drop      = 1'b1;
          end else begin
            w_state_nxt = ST_DATA;
            w_start     = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (!rx_dv_i) w_state_nxt = ST_COMMIT;
        else if (w_byte_done) begin
          if (r_byte_cnt == MAX_L) begin
            w_state_nxt = ST_DROP;
            w_drop      = 1'b1;
          end else begin
            w_wr = 1'b1;
          end
        end
      end
      ST_DROP: if (!rx_dv_i) w_state_nxt = ST_IDLE;
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        if (r_byte_cnt < MIN_L) w_drop = 1'b1;
        else                    w_push = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  iob_eth_crc32 u_crc (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .clr_i  (w_start),
    .en_i   (w_wr),
    .data_i (w_byte),
    .crc_o  (w_crc)
  );

  // Datapath and descriptor queue. Slots are filled and pushed strictly in order.
  // The queue tail therefore always equals r_wr_slot, and the head index is the
  // slot of the head descriptor. Neither needs to be stored per entry.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_byte_cnt <= '0;
      r_wr_slot  <= '0;
      r_head     <= '0;
      r_count    <= '0;
      r_er       <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_drop_cnt <= '0;
      r_q_len    <= '0;
      r_q_err    <= '0;
    end else if (cke_i) begin
      r_wr_en <= w_wr;
      if (w_start) begin
        r_byte_cnt <= '0;
        r_er       <= 1'b0;
      end
      if (w_wr) begin
        r_wr_addr  <= {r_wr_slot, r_byte_cnt};
        r_wr_data  <= w_byte;
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (r_state == ST_DATA && rx_dv_i && rx_er_i) r_er <= 1'b1;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_push) begin
        r_q_len[r_wr_slot] <= r_byte_cnt;
        r_q_err[r_wr_slot] <= {r_er, w_crc_err};
        r_wr_slot          <= r_wr_slot + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign wr_en_o      = r_wr_en & cke_i;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign desc_valid_o = (r_count != '0);
  assign desc_slot_o  = r_head;
  assign desc_len_o   = r_q_len[r_head];
  assign desc_err_o   = r_q_err[r_head];
  assign drop_cnt_o   = r_drop_cnt;
endmodule
